// File: rtl/fft_bitrev_serializer.sv
// fft_bitrev_serializer
//   Output stage for the combinational radix-2 DIT FFT core. Captures a whole
//   frame of bit-reversed bins in one cycle, reordering them into natural order
//   as they are written, then streams them out one bin per cycle over a
//   valid/ready handshake.
//
// Ports
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   frame_valid_i  data_i holds a complete FFT frame
//   frame_ready_o  frame can be captured this cycle
//   data_i         POINT_FFT bins, bit-reversed order; [k][0]=Re, [k][1]=Im
//   valid_o        bin_o/idx_o/last_o valid
//   ready_i        downstream accepts the current bin
//   bin_o          current bin, [0]=Re, [1]=Im, signed Q1.FRAC_BITS
//   idx_o          natural-order index of bin_o
//   last_o         high on the final bin of a frame
module fft_bitrev_serializer #(
    parameter int unsigned POINT_FFT_POW2 = 4,
    parameter int unsigned FRAC_BITS      = 15,
    localparam int unsigned POINT_FFT     = 1 << POINT_FFT_POW2
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    frame_valid_i,
    output logic                                    frame_ready_o,
    input  logic [POINT_FFT-1:0][1:0][FRAC_BITS:0]  data_i,
    output logic                                    valid_o,
    input  logic                                    ready_i,
    output logic [1:0][FRAC_BITS:0]                 bin_o,
    output logic [POINT_FFT_POW2-1:0]               idx_o,
    output logic                                    last_o
);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e                                 state_q, state_d;
    logic [POINT_FFT_POW2-1:0]              rd_q, rd_d;
    logic [POINT_FFT-1:0][1:0][FRAC_BITS:0] frame_q, frame_d;
    logic                                   accept;

    function automatic logic [POINT_FFT_POW2-1:0] bitrev(input logic [POINT_FFT_POW2-1:0] k);
        logic [POINT_FFT_POW2-1:0] r;
        for (int b = 0; b < int'(POINT_FFT_POW2); b++) begin
            r[b] = k[int'(POINT_FFT_POW2) - 1 - b];
        end
        return r;
    endfunction

    // Outputs decode directly from registered state, so they are glitch-free
    // and stay put during a stall. bin_o is forced to zero outside STREAM so
    // the stale buffer never shows after reset.
    always_comb begin
        valid_o       = (state_q == StStream);
        idx_o         = rd_q;
        last_o        = valid_o && (&rd_q);
        bin_o         = valid_o ? frame_q[rd_q] : '0;
        // In STREAM a new frame may only land on the final accepted beat,
        // which gives zero-bubble back-to-back frames.
        frame_ready_o = (state_q == StIdle) || (ready_i && last_o);
        accept        = frame_valid_i && frame_ready_o;
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        frame_d = frame_q;
        if (valid_o && ready_i) begin
            // rd wraps to zero naturally after the last bin.
            rd_d = rd_q + POINT_FFT_POW2'(1);
            if (last_o) begin
                state_d = StIdle;
            end
        end
        if (accept) begin
            state_d = StStream;
            rd_d    = '0;
            for (int k = 0; k < int'(POINT_FFT); k++) begin
                frame_d[k] = data_i[bitrev(POINT_FFT_POW2'(k))];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
        end
    end

    // Buffer contents are meaningless until a frame is captured, so no reset.
    always_ff @(posedge clk_i) begin
        frame_q <= frame_d;
    end

endmodule

// File: tb/tb_fft_bitrev_serializer.sv
// tb_fft_bitrev_serializer
//   Directed bench for fft_bitrev_serializer (N=16, Q1.15). Each task drives one
//   scenario and compares outputs against hand-derived bit-reversal indices.
module tb_fft_bitrev_serializer;

    typedef logic [15:0][1:0][15:0] frame_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        frame_valid_i = 1'b0;
    logic        frame_ready_o;
    frame_t      data_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [1:0][15:0] bin_o;
    logic [3:0]  idx_o;
    logic        last_o;

    int total = 0;
    int bad = 0;

    // bitrev4(i), worked out by hand
    int br[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    fft_bitrev_serializer #(
        .POINT_FFT_POW2(4),
        .FRAC_BITS     (15)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .frame_valid_i(frame_valid_i),
        .frame_ready_o(frame_ready_o),
        .data_i       (data_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .bin_o        (bin_o),
        .idx_o        (idx_o),
        .last_o       (last_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #3;
        total++;
        if (valid_o !== 1'b0 || last_o !== 1'b0 || idx_o !== 4'd0 || bin_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%b last=%b idx=%0d bin=%h want 0 0 0 0",
                     valid_o, last_o, idx_o, bin_o);
        end
        total++;
        if (frame_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1", frame_ready_o);
        end
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_natural_order();
        frame_t f;
        for (int k = 0; k < 16; k++) f[k] = {16'(-k), 16'(k)};
        data_i = f;
        frame_valid_i = 1'b1;
        ready_i = 1'b1;
        total++;
        if (valid_o !== 1'b0 || frame_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL order_pre: valid=%b ready=%b want 0 1", valid_o, frame_ready_o);
        end
        tick();
        frame_valid_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (valid_o !== 1'b1 || idx_o !== 4'(i) || last_o !== (i == 15) ||
                bin_o[0] !== 16'(br[i]) || bin_o[1] !== 16'(-br[i])) begin
                bad++;
                $display("FAIL order_beat%0d: v=%b idx=%0d last=%b re=%h im=%h want re=%h im=%h",
                         i, valid_o, idx_o, last_o, bin_o[0], bin_o[1],
                         16'(br[i]), 16'(-br[i]));
            end
            tick();
        end
        total++;
        if (valid_o !== 1'b0) begin
            bad++;
            $display("FAIL order_end: valid=%b want 0", valid_o);
        end
    endtask

    task automatic test_impulse();
        frame_t f;
        for (int k = 0; k < 16; k++) f[k] = {16'd0, 16'd16384};
        data_i = f;
        frame_valid_i = 1'b1;
        ready_i = 1'b1;
        tick();
        frame_valid_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (valid_o !== 1'b1 || idx_o !== 4'(i) || bin_o[0] !== 16'd16384 ||
                bin_o[1] !== 16'd0) begin
                bad++;
                $display("FAIL impulse_beat%0d: v=%b idx=%0d re=%h im=%h want re=4000 im=0000",
                         i, valid_o, idx_o, bin_o[0], bin_o[1]);
            end
            tick();
        end
    endtask

    task automatic test_random_stall();
        frame_t frames[3];
        int fin = 0;
        int oc = 0;
        int cyc = 0;
        logic acc;
        logic hs;
        logic prev_stall = 1'b0;
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < 16; k++) frames[f][k] = $urandom;
        while (oc < 48 && cyc < 2000) begin
            if (prev_stall) begin
                total++;
                if (valid_o !== 1'b1) begin
                    bad++;
                    $display("FAIL stall_drop: valid=%b want 1 at beat %0d", valid_o, oc);
                end
            end
            if (valid_o) begin
                total++;
                if (idx_o !== 4'(oc % 16) || last_o !== (oc % 16 == 15) ||
                    bin_o !== frames[oc / 16][br[oc % 16]]) begin
                    bad++;
                    $display("FAIL stall_beat%0d: idx=%0d last=%b bin=%h want idx=%0d bin=%h",
                             oc, idx_o, last_o, bin_o, oc % 16, frames[oc / 16][br[oc % 16]]);
                end
            end
            frame_valid_i = (fin < 3);
            if (fin < 3) data_i = frames[fin];
            ready_i = 1'($urandom % 2);
            #1;
            acc = frame_valid_i && frame_ready_o;
            hs = valid_o && ready_i;
            prev_stall = valid_o && !ready_i;
            tick();
            if (acc) fin++;
            if (hs) oc++;
            cyc++;
        end
        frame_valid_i = 1'b0;
        ready_i = 1'b0;
        total++;
        if (oc != 48 || valid_o !== 1'b0) begin
            bad++;
            $display("FAIL stall_count: beats=%0d valid=%b want 48 0", oc, valid_o);
        end
    endtask

    task automatic test_back_to_back();
        frame_t frames[4];
        int fin = 0;
        logic acc;
        for (int f = 0; f < 4; f++)
            for (int k = 0; k < 16; k++) frames[f][k] = {16'(k), 16'(f * 16 + k)};
        ready_i = 1'b1;
        frame_valid_i = 1'b1;
        data_i = frames[0];
        #1;
        total++;
        if (valid_o !== 1'b0 || frame_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL b2b_idle: valid=%b ready=%b want 0 1", valid_o, frame_ready_o);
        end
        tick();
        fin = 1;
        data_i = frames[1];
        for (int b = 0; b < 64; b++) begin
            #1;
            total++;
            if (valid_o !== 1'b1 || idx_o !== 4'(b % 16) || bin_o !== frames[b / 16][br[b % 16]]
                || frame_ready_o !== (b % 16 == 15)) begin
                bad++;
                $display("FAIL b2b_beat%0d: v=%b idx=%0d bin=%h fready=%b want bin=%h fready=%b",
                         b, valid_o, idx_o, bin_o, frame_ready_o, frames[b / 16][br[b % 16]],
                         (b % 16 == 15));
            end
            acc = frame_valid_i && frame_ready_o;
            tick();
            if (acc) begin
                fin++;
                if (fin < 4) data_i = frames[fin];
                else frame_valid_i = 1'b0;
            end
        end
        total++;
        if (valid_o !== 1'b0 || fin != 4) begin
            bad++;
            $display("FAIL b2b_end: valid=%b frames=%0d want 0 4", valid_o, fin);
        end
    endtask

    task automatic test_reset_midframe();
        frame_t f;
        for (int k = 0; k < 16; k++) f[k] = {16'(k + 200), 16'(k + 100)};
        data_i = f;
        ready_i = 1'b1;
        frame_valid_i = 1'b1;
        tick();
        frame_valid_i = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        total++;
        if (idx_o !== 4'd7) begin
            bad++;
            $display("FAIL midrst_pre: idx=%0d want 7", idx_o);
        end
        rst_ni = 1'b0;
        #1;
        total++;
        if (valid_o !== 1'b0 || idx_o !== 4'd0 || last_o !== 1'b0 || bin_o !== 32'h0 ||
            frame_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL midrst_async: v=%b idx=%0d last=%b bin=%h fready=%b want 0 0 0 0 1",
                     valid_o, idx_o, last_o, bin_o, frame_ready_o);
        end
        #2;
        rst_ni = 1'b1;
        tick();
        total++;
        if (valid_o !== 1'b0 || frame_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL midrst_release: v=%b fready=%b want 0 1", valid_o, frame_ready_o);
        end
        for (int k = 0; k < 16; k++) f[k] = {16'(k + 400), 16'(k + 300)};
        data_i = f;
        frame_valid_i = 1'b1;
        tick();
        frame_valid_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (valid_o !== 1'b1 || idx_o !== 4'(i) || bin_o !== f[br[i]]) begin
                bad++;
                $display("FAIL midrst_beat%0d: v=%b idx=%0d bin=%h want bin=%h",
                         i, valid_o, idx_o, bin_o, f[br[i]]);
            end
            tick();
        end
    endtask

    task automatic test_extremes();
        frame_t f;
        for (int k = 0; k < 16; k++) f[k] = {16'h7fff, 16'h8000};
        data_i = f;
        ready_i = 1'b1;
        frame_valid_i = 1'b1;
        tick();
        frame_valid_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (valid_o !== 1'b1 || bin_o[0] !== 16'h8000 || bin_o[1] !== 16'h7fff) begin
                bad++;
                $display("FAIL extreme_beat%0d: v=%b re=%h im=%h want re=8000 im=7fff",
                         i, valid_o, bin_o[0], bin_o[1]);
            end
            tick();
        end
        total++;
        if (valid_o !== 1'b0) begin
            bad++;
            $display("FAIL extreme_end: valid=%b want 0", valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_natural_order();
        test_impulse();
        test_random_stall();
        test_back_to_back();
        test_reset_midframe();
        test_extremes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
